// File: rtl/inst_fetch_unit_if.sv
// rtl/inst_fetch_unit_if.sv - redirect, imem request/response and decode handshake bundle
//
// Purpose: groups every handshake/bus signal of the fetch unit so the unit and its
// environment connect through one port.
// Signals:
//   redirect_valid, redirect_pc     redirect request from execute (taken branch/jump)
//   imem_req_valid/addr/ready       fetch request channel to instruction memory
//   imem_resp_valid/data            in-order response channel from instruction memory
//   inst_valid/inst/inst_pc/ready   fetched instruction stream to decode
// Modports:
//   master  the fetch unit side
//   slave   the surrounding environment (memory, execute, decode)

interface inst_fetch_unit_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    input  redirect_valid,
    input  redirect_pc,
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data,
    output inst_valid,
    output inst,
    output inst_pc,
    input  inst_ready
  );

  modport slave (
    output redirect_valid,
    output redirect_pc,
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data,
    input  inst_valid,
    input  inst,
    input  inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - instruction fetch unit with request FSM and {pc, inst} queue
//
// Purpose: owns the fetch PC, issues at most one outstanding request to instruction
// memory, and buffers returned {pc, inst} pairs in a QUEUE_DEPTH-entry queue that
// drains to decode. A redirect flushes the queue and restarts fetch at the new PC;
// a response still in flight at that moment is discarded when it arrives.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous reset, active low
//   bus    inst_fetch_unit_if.master (redirect, imem request/response, decode stream)
// Parameters:
//   RESET_PC     fetch address after reset
//   QUEUE_DEPTH  queue entries, power of two, >= 2

module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  inst_fetch_unit_if.master  bus
);

  localparam int                PTR_W      = $clog2(QUEUE_DEPTH);
  localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W + 1)'(QUEUE_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);

  // REQ: may issue; WAIT: one request in flight; DROP: in-flight response is stale.
  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t            state;
  logic [31:0]       fetch_pc;
  logic [31:0]       req_pc;
  logic [31:0]       q_inst [QUEUE_DEPTH];
  logic [31:0]       q_pc   [QUEUE_DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W:0]    count;

  logic              req_fire;
  logic              push;
  logic              pop;

  // A request only goes out with a free slot; that slot stays reserved until the
  // response lands, since nothing else pushes while a request is in flight.
  always_comb begin
    bus.imem_req_valid = (state == REQ) && (count < FULL_COUNT) && !bus.redirect_valid;
    bus.imem_req_addr  = fetch_pc;
    bus.inst_valid     = (count != '0);
    bus.inst           = q_inst[head];
    bus.inst_pc        = q_pc[head];
  end

  always_comb begin
    req_fire = bus.imem_req_valid && bus.imem_req_ready;
    push     = (state == WAIT) && bus.imem_resp_valid && !bus.redirect_valid;
    pop      = bus.inst_valid && bus.inst_ready && !bus.redirect_valid;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= REQ;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_inst[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else if (bus.redirect_valid) begin
      // Flush wins over any same-cycle push, pop or request.
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
      case (state)
        WAIT:    state <= bus.imem_resp_valid ? REQ : DROP;
        DROP:    state <= bus.imem_resp_valid ? REQ : DROP;
        default: state <= REQ;
      endcase
    end else begin
      case (state)
        REQ: begin
          // A response arriving in REQ is a protocol error and is ignored.
          if (req_fire) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + 32'd4;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (bus.imem_resp_valid) state <= REQ;
        end
        DROP: begin
          if (bus.imem_resp_valid) state <= REQ;
        end
        default: state <= REQ;
      endcase

      if (push) begin
        q_inst[tail] <= bus.imem_resp_data;
        q_pc[tail]   <= req_pc;
        tail         <= tail + PTR_ONE;
      end
      if (pop) begin
        head <= head + PTR_ONE;
      end

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - self-checking bench for inst_fetch_unit

module tb_inst_fetch_unit;
  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  inst_fetch_unit_if bus();

  inst_fetch_unit #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  // reference model: queue of fetched pairs plus in-flight bookkeeping
  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_fetch;
  logic [31:0] m_req_pc;
  bit          m_out;
  bit          m_disc;

  // memory model
  bit          mem_pend;
  logic [31:0] mem_addr;
  int          mem_dly;

  // outputs sampled in the last cycle
  logic        s_rv, s_iv;
  logic [31:0] s_addr, s_inst, s_ipc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cycle(input bit rst_i, input bit rdr, input logic [31:0] rpc,
                       input bit rrdy, input bit irdy, input int lat);
    bit          resp;
    bit          exp_rv;
    bit          req_fire;
    bit          pop;
    reset              = !rst_i;
    bus.redirect_valid = rdr;
    bus.redirect_pc    = rpc;
    bus.imem_req_ready = rrdy;
    bus.inst_ready     = irdy;
    resp               = mem_pend && (mem_dly == 0);
    bus.imem_resp_valid = resp;
    bus.imem_resp_data  = resp ? ~mem_addr : $urandom;
    #1;
    s_rv   = bus.imem_req_valid;
    s_addr = bus.imem_req_addr;
    s_iv   = bus.inst_valid;
    s_inst = bus.inst;
    s_ipc  = bus.inst_pc;
    if (cmp_en) begin
      exp_rv = !m_out && (mq.size() < DEPTH) && !rdr;
      chk("model_req_valid", {31'd0, s_rv}, {31'd0, exp_rv});
      if (exp_rv) chk("model_req_addr", s_addr, m_fetch);
      chk("model_inst_valid", {31'd0, s_iv}, {31'd0, mq.size() != 0});
      if (mq.size() != 0) begin
        chk("model_inst_pc", s_ipc, mq[0].pc);
        chk("model_inst", s_inst, mq[0].ins);
      end
    end
    if (rst_i) begin
      mq.delete();
      m_fetch  = 32'h0;
      m_out    = 0;
      m_disc   = 0;
      mem_pend = 0;
    end else begin
      req_fire = s_rv && rrdy;
      pop      = s_iv && irdy;
      if (rdr) begin
        mq.delete();
        m_fetch = {rpc[31:2], 2'b00};
        if (m_out) begin
          if (resp) begin m_out = 0; m_disc = 0; end
          else m_disc = 1;
        end
      end else begin
        if (pop && mq.size() != 0) void'(mq.pop_front());
        if (m_out && resp) begin
          if (!m_disc) mq.push_back('{pc: m_req_pc, ins: ~m_req_pc});
          m_out  = 0;
          m_disc = 0;
        end else if (!m_out && req_fire) begin
          m_req_pc = m_fetch;
          m_fetch  = m_fetch + 32'd4;
          m_out    = 1;
        end
      end
      if (resp) mem_pend = 0;
      else if (mem_pend && mem_dly > 0) mem_dly--;
      if (req_fire) begin
        mem_pend = 1;
        mem_addr = s_addr;
        mem_dly  = lat;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    bit          rst;
    bit          rrdy;
    bit          irdy;
    bit          e_rv;
    logic [31:0] e_addr;
    bit          e_iv;
    logic [31:0] e_ipc;
  } vec_t;
  vec_t vt[$];

  function automatic vec_t mk(bit rst, bit rrdy, bit irdy, bit e_rv, logic [31:0] e_addr,
                              bit e_iv, logic [31:0] e_ipc);
    vec_t v;
    v.rst = rst; v.rrdy = rrdy; v.irdy = irdy;
    v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_ipc = e_ipc;
    return v;
  endfunction

  initial begin
    int          n;
    int          got;
    logic [31:0] seen [3];
    logic [31:0] want [3];
    logic [31:0] rpc;

    // next-cycle memory, decode always ready
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 1, 1, 1, 32'h0,  0, 32'h0));
    vt.push_back(mk(0, 1, 1, 0, 32'h0,  0, 32'h0));
    vt.push_back(mk(0, 1, 1, 1, 32'h4,  1, 32'h0));
    vt.push_back(mk(0, 1, 1, 0, 32'h0,  0, 32'h0));
    vt.push_back(mk(0, 1, 1, 1, 32'h8,  1, 32'h4));
    vt.push_back(mk(0, 1, 1, 0, 32'h0,  0, 32'h0));
    vt.push_back(mk(0, 1, 1, 1, 32'hC,  1, 32'h8));
    vt.push_back(mk(0, 1, 1, 0, 32'h0,  0, 32'h0));
    vt.push_back(mk(0, 1, 1, 1, 32'h10, 1, 32'hC));
    // decode stalled until full, then drains
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 1, 0, 1, 32'h0,  0, 32'h0));
    vt.push_back(mk(0, 1, 0, 0, 32'h0,  0, 32'h0));
    vt.push_back(mk(0, 1, 0, 1, 32'h4,  1, 32'h0));
    vt.push_back(mk(0, 1, 0, 0, 32'h0,  1, 32'h0));
    vt.push_back(mk(0, 1, 0, 1, 32'h8,  1, 32'h0));
    vt.push_back(mk(0, 1, 0, 0, 32'h0,  1, 32'h0));
    vt.push_back(mk(0, 1, 0, 1, 32'hC,  1, 32'h0));
    vt.push_back(mk(0, 1, 0, 0, 32'h0,  1, 32'h0));
    vt.push_back(mk(0, 1, 0, 0, 32'h0,  1, 32'h0));
    vt.push_back(mk(0, 1, 0, 0, 32'h0,  1, 32'h0));
    vt.push_back(mk(0, 1, 1, 0, 32'h0,  1, 32'h0));
    vt.push_back(mk(0, 1, 1, 1, 32'h10, 1, 32'h4));
    vt.push_back(mk(0, 1, 1, 0, 32'h0,  1, 32'h8));
    vt.push_back(mk(0, 1, 1, 1, 32'h14, 1, 32'hC));
    vt.push_back(mk(0, 1, 1, 0, 32'h0,  1, 32'h10));
    // memory not ready for three cycles at 0x8
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 1, 1, 1, 32'h0,  0, 32'h0));
    vt.push_back(mk(0, 1, 1, 0, 32'h0,  0, 32'h0));
    vt.push_back(mk(0, 1, 1, 1, 32'h4,  1, 32'h0));
    vt.push_back(mk(0, 1, 1, 0, 32'h0,  0, 32'h0));
    vt.push_back(mk(0, 0, 1, 1, 32'h8,  1, 32'h4));
    vt.push_back(mk(0, 0, 1, 1, 32'h8,  0, 32'h0));
    vt.push_back(mk(0, 0, 1, 1, 32'h8,  0, 32'h0));
    vt.push_back(mk(0, 1, 1, 1, 32'h8,  0, 32'h0));
    vt.push_back(mk(0, 1, 1, 0, 32'h0,  0, 32'h0));
    vt.push_back(mk(0, 1, 1, 1, 32'hC,  1, 32'h8));
    vt.push_back(mk(0, 1, 1, 0, 32'h0,  0, 32'h0));
    vt.push_back(mk(0, 0, 1, 1, 32'h10, 1, 32'hC));
    vt.push_back(mk(0, 0, 1, 1, 32'h10, 0, 32'h0));

    mem_pend = 0; mem_dly = 0; mem_addr = 0;
    m_fetch = 0; m_req_pc = 0; m_out = 0; m_disc = 0;

    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cmp_en = 1;

    // reset state
    cycle(0, 0, 0, 0, 0, 0);
    chk("rst_req_valid", {31'd0, s_rv}, 32'd1);
    chk("rst_req_addr", s_addr, 32'h0);
    chk("rst_inst_valid", {31'd0, s_iv}, 32'd0);
    chk("rst_inst", s_inst, 32'h0);
    chk("rst_inst_pc", s_ipc, 32'h0);

    for (int i = 0; i < vt.size(); i++) begin
      cycle(vt[i].rst, 0, 32'h0, vt[i].rrdy, vt[i].irdy, 0);
      if (!vt[i].rst) begin
        chk($sformatf("vec%0d_req_valid", i), {31'd0, s_rv}, {31'd0, vt[i].e_rv});
        if (vt[i].e_rv) chk($sformatf("vec%0d_req_addr", i), s_addr, vt[i].e_addr);
        chk($sformatf("vec%0d_inst_valid", i), {31'd0, s_iv}, {31'd0, vt[i].e_iv});
        if (vt[i].e_iv) begin
          chk($sformatf("vec%0d_inst_pc", i), s_ipc, vt[i].e_ipc);
          chk($sformatf("vec%0d_inst", i), s_inst, ~vt[i].e_ipc);
        end
      end
    end

    // redirect to 0x103 while the request for 0x4 is in flight
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 0);
    cycle(0, 0, 0, 1, 1, 0);
    cycle(0, 0, 0, 1, 1, 3);
    chk("t4_req_addr_4", s_addr, 32'h4);
    cycle(0, 1, 32'h103, 1, 1, 0);
    n = 0;
    s_rv = 0;
    while (!s_rv && n < 20) begin
      cycle(0, 0, 0, 0, 1, 0);
      chk("t4_no_entry", {31'd0, s_iv}, 32'd0);
      n++;
    end
    chk("t4_req_seen", {31'd0, s_rv}, 32'd1);
    chk("t4_req_addr", s_addr, 32'h100);
    n = 0;
    s_iv = 0;
    while (!s_iv && n < 20) begin
      cycle(0, 0, 0, 1, 0, 0);
      n++;
    end
    chk("t4_inst_seen", {31'd0, s_iv}, 32'd1);
    chk("t4_inst_pc", s_ipc, 32'h100);
    chk("t4_inst", s_inst, ~32'h100);

    // wrap through the top of the address space
    cycle(0, 1, 32'hFFFF_FFFC, 1, 1, 0);
    want[0] = 32'hFFFF_FFFC; want[1] = 32'h0; want[2] = 32'h4;
    got = 0;
    n = 0;
    while (got < 3 && n < 60) begin
      cycle(0, 0, 0, 1, 1, $urandom_range(0, 2));
      if (s_iv) begin
        seen[got] = s_ipc;
        got++;
      end
      n++;
    end
    chk("t5_count", got, 3);
    for (int i = 0; i < got; i++) chk($sformatf("t5_pc%0d", i), seen[i], want[i]);

    // reset with three queued entries
    cycle(1, 0, 0, 0, 0, 0);
    n = 0;
    while (mq.size() < 3 && n < 30) begin
      cycle(0, 0, 0, 1, 0, 0);
      n++;
    end
    chk("t6_three_queued", {31'd0, s_iv}, 32'd1);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("t6_inst_valid", {31'd0, s_iv}, 32'd0);
    chk("t6_req_valid", {31'd0, s_rv}, 32'd1);
    chk("t6_req_addr", s_addr, 32'h0);
    n = 0;
    s_iv = 0;
    while (!s_iv && n < 20) begin
      cycle(0, 0, 0, 1, 1, 0);
      n++;
    end
    chk("t6_restart_pc", s_ipc, 32'h0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) < 3) begin
        cycle(1, 0, 0, 0, 0, 0);
      end else begin
        case ($urandom_range(0, 2))
          0:       rpc = $urandom;
          1:       rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
          default: rpc = 32'($urandom_range(0, 255));
        endcase
        cycle(0, $urandom_range(0, 99) < 3, rpc, $urandom_range(0, 9) < 7,
              $urandom_range(0, 9) < 6, $urandom_range(0, 3));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
